// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU opcode bit positions,
// the decode-to-execute and execute-to-memory bus layouts, and divider states.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 153;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ALU_OP_WD       = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order matches the packed bus, MSB first.
  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 div_en;
    logic                 div_signed;
    logic                 div_mod;
    logic                 res_from_mem;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [31:0]          imm;
    logic [31:0]          rj_value;
    logic [31:0]          rkd_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  function automatic logic [31:0] neg_if(input logic [31:0] value, input logic neg);
    return neg ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/exe_stage_div.sv
// 32-step restoring divider for div/mod instructions. Works on magnitudes and
// applies the sign correction combinationally on the held result.
//
// state | meaning
// IDLE  | waiting for a divide instruction in ES; operands loaded on start
// BUSY  | one shift-subtract step per cycle, cnt counts steps 0..31
// DONE  | sign-corrected quotient/remainder held until MS consumes the instruction
module div_unit
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        consume,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        q_neg, r_neg;

  logic        a_neg, b_neg;
  logic [32:0] r_shift;
  logic [31:0] r_sub;
  logic        r_ge;

  assign a_neg = div_signed & dividend[31];
  assign b_neg = div_signed & divisor[31];

  // Partial remainder stays below the divisor, so 32 bits suffice; the shifted
  // value needs one extra bit only for the compare.
  assign r_shift = {rem, quo[31]};
  assign r_sub   = r_shift[31:0] - dvs;
  assign r_ge    = r_shift >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start)          state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31)   state_nxt = DIV_DONE;
      DIV_DONE: if (consume)        state_nxt = DIV_IDLE;
      default:                      state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 5'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt   <= 5'd0;
            rem   <= 32'd0;
            quo   <= neg_if(dividend, a_neg);
            dvs   <= neg_if(divisor, b_neg);
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
          end
        end
        DIV_BUSY: begin
          cnt <= cnt + 5'd1;
          rem <= r_ge ? r_sub : r_shift[31:0];
          quo <= {quo[30:0], r_ge};
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = neg_if(quo, q_neg);
  assign remainder = neg_if(rem, r_neg);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, evaluates the ALU, sequences divides
// through div_unit and issues the data-SRAM request on handoff to MS.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_to_es_t   es_bus;
  es_to_ms_t   ms_out;
  logic        es_valid;
  logic        es_ready_go;
  logic        div_done;
  logic [31:0] div_quotient, div_remainder;

  logic [31:0] src1, src2;
  logic [31:0] add_res, sub_res, sll_res, srl_res, sra_res;
  logic        slt_res, sltu_res;
  logic [31:0] alu_out;
  logic [31:0] es_result;

  assign es_ready_go    = !es_bus.div_en | div_done;
  assign es_allowin     = !es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      es_bus <= ds_to_es_bus;
    end
  end

  assign src1 = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj_value;
  assign src2 = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd_value;

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;
  assign sll_res  = src1 << src2[4:0];
  assign srl_res  = src1 >> src2[4:0];
  assign sra_res  = $signed(src1) >>> src2[4:0];

  // alu_op is one-hot, so an AND-OR mux is enough.
  assign alu_out = ({32{es_bus.alu_op[ALU_ADD ]}} & add_res)
                 | ({32{es_bus.alu_op[ALU_SUB ]}} & sub_res)
                 | ({32{es_bus.alu_op[ALU_SLT ]}} & {31'd0, slt_res})
                 | ({32{es_bus.alu_op[ALU_SLTU]}} & {31'd0, sltu_res})
                 | ({32{es_bus.alu_op[ALU_AND ]}} & (src1 & src2))
                 | ({32{es_bus.alu_op[ALU_NOR ]}} & ~(src1 | src2))
                 | ({32{es_bus.alu_op[ALU_OR  ]}} & (src1 | src2))
                 | ({32{es_bus.alu_op[ALU_XOR ]}} & (src1 ^ src2))
                 | ({32{es_bus.alu_op[ALU_SLL ]}} & sll_res)
                 | ({32{es_bus.alu_op[ALU_SRL ]}} & srl_res)
                 | ({32{es_bus.alu_op[ALU_SRA ]}} & sra_res)
                 | ({32{es_bus.alu_op[ALU_LUI ]}} & src2);

  div_unit u_div (
    .clk        (clk),
    .reset      (reset),
    .start      (es_valid & es_bus.div_en),
    .div_signed (es_bus.div_signed),
    .dividend   (es_bus.rj_value),
    .divisor    (es_bus.rkd_value),
    .consume    (es_to_ms_valid & ms_allowin),
    .done       (div_done),
    .quotient   (div_quotient),
    .remainder  (div_remainder)
  );

  assign es_result = es_bus.div_en ? (es_bus.div_mod ? div_remainder : div_quotient)
                                   : alu_out;

  assign ms_out.res_from_mem = es_bus.res_from_mem;
  assign ms_out.gr_we        = es_bus.gr_we;
  assign ms_out.dest         = es_bus.dest;
  assign ms_out.result       = es_result;
  assign ms_out.pc           = es_bus.pc;
  assign es_to_ms_bus        = ms_out;

  // Request only on the handoff cycle so a stalled memory op is issued once.
  assign data_sram_en    = es_valid & es_ready_go & ms_allowin
                         & (es_bus.res_from_mem | es_bus.mem_we);
  assign data_sram_we    = {4{es_bus.mem_we & data_sram_en}};
  assign data_sram_addr  = alu_out;
  assign data_sram_wdata = es_bus.rkd_value;

endmodule
